// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the only arithmetic element of the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial two's-complement add/subtract sequencing one full_adder over WIDTH cycles.
// Define SERIAL_ADD_OVF_EN to compute signed overflow; otherwise ovf is tied low.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] sum_sh;
  logic [WIDTH-1:0] sum_shifted;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Handshake: a request is taken on a rising edge with start=1 and ready=1;
  // ready is high only in IDLE, valid only in DONE, so they never overlap.
  assign ready       = (state == IDLE);
  assign valid       = (state == DONE);
  assign last_bit    = (cnt == LAST_CNT);
  assign sum_shifted = {fa_s, sum_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          sum_sh <= sum_shifted[WIDTH-1:1];
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          carry  <= fa_co;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            sum  <= sum_shifted;
            cout <= fa_co;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // On the last bit, carry holds the carry into the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         ovf <= 1'b0;
    else if ((state == RUN) && last_bit) ovf <= carry ^ fa_co;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases, handshake/abort and random back-to-back ops.
module tb_serial_adder_ctrl;
  import serial_adder_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         valid;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  logic [W+1:0] exp_q[$];   // {ovf, cout, sum}
  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] last_sum  = '0;
  logic         last_cout = 1'b0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .ready (ready),
    .valid (valid),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [W+1:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts);
    logic [W-1:0] bb;
    logic [W:0]   r;
    logic         ov;
    bb = ts ? ~tb_ : tb_;
    r  = {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, ts};
`ifdef SERIAL_ADD_OVF_EN
    ov = (ta[W-1] == bb[W-1]) && (r[W-1] != ta[W-1]);
`else
    ov = 1'b0;
`endif
    return {ov, r};
  endfunction

  // Starts and ends at a falling edge with the DUT idle.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                        input bit inject, input string name);
    logic [W+1:0] exp;
    bit seen;
    bit stable_ok;
    bit overlap;
    int lat;
    exp_q.push_back(model(ta, tb_, ts));
    a = ta; b = tb_; sub = ts; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    seen = 0; stable_ok = 1; overlap = 0; lat = 0;
    for (int e = 1; e <= 3 * W && !seen; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready && valid) overlap = 1;
      if (valid) begin
        seen = 1;
        lat  = e;
      end else if (sum !== last_sum || cout !== last_cout) begin
        stable_ok = 0;
      end
      if (inject && e == 3) begin
        start = 1'b1; a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      end
      if (inject && e == 4) start = 1'b0;
    end
    total++;
    if (lat !== W) begin
      bad++;
      $display("FAIL %s latency: got %0d edges after accept, want %0d", name, lat, W);
    end
    exp = exp_q.pop_front();
    total++;
    if (sum !== exp[W-1:0]) begin
      bad++;
      $display("FAIL %s sum: got %h want %h", name, sum, exp[W-1:0]);
    end
    total++;
    if (cout !== exp[W]) begin
      bad++;
      $display("FAIL %s cout: got %b want %b", name, cout, exp[W]);
    end
    total++;
    if (ovf !== exp[W+1]) begin
      bad++;
      $display("FAIL %s ovf: got %b want %b", name, ovf, exp[W+1]);
    end
    total++;
    if (!stable_ok || overlap) begin
      bad++;
      $display("FAIL %s hold: stable=%0b ready_valid_overlap=%0b want 1/0", name, stable_ok, overlap);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || valid !== 1'b0) begin
      bad++;
      $display("FAIL %s return_idle: ready=%b valid=%b want 1/0", name, ready, valid);
    end
    last_sum  = exp[W-1:0];
    last_cout = exp[W];
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if (ready !== 1'b1 || valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL %s: ready=%b valid=%b sum=%h cout=%b ovf=%b want 1 0 00 0 0",
               name, ready, valid, sum, cout, ovf);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_hold");
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_release");
  endtask

  task automatic test_directed;
    run_op(8'h05, 8'h03, 1'b0, 0, "basic_add");
    run_op(8'hFF, 8'h01, 1'b0, 0, "unsigned_wrap");
    run_op(8'h05, 8'h07, 1'b1, 0, "sub_borrow");
    run_op(8'h80, 8'h01, 1'b1, 0, "sub_ovf");
    run_op(8'h7F, 8'h01, 1'b0, 0, "add_ovf");
    run_op(8'h33, 8'h00, 1'b1, 0, "sub_zero");
  endtask

  task automatic test_mid_start;
    run_op(8'h3C, 8'h11, 1'b0, 1, "mid_run_start");
  endtask

  task automatic test_abort;
    bit spurious;
    a = 8'h5A; b = 8'h33; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort_async");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (valid !== 1'b0 || ready !== 1'b1) spurious = 1;
    end
    total++;
    if (spurious) begin
      bad++;
      $display("FAIL abort_quiet: valid or non-ready seen after abort, want valid=0 ready=1");
    end
    last_sum = '0;
    last_cout = 1'b0;
    run_op(8'h10, 8'h20, 1'b0, 0, "after_abort");
  endtask

  task automatic test_corners;
    logic [W-1:0] vals [5];
    vals = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        for (int s = 0; s < 2; s++)
          run_op(vals[i], vals[j], 1'(s), 0, "corner");
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 2000; n++)
      run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0, "random");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_mid_start();
    test_abort();
    test_corners();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
